// File: rtl/button_event_decoder.sv
// Turns a debounced switch level into single-cycle press/release/click/long/repeat events.
// All timing comes from a local tick prescaler, and every output is registered.
module button_event_decoder #(
  parameter int TICK_M       = 1_000_000,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic db,
  output logic press_tick,
  output logic release_tick,
  output logic click_tick,
  output logic long_tick,
  output logic repeat_tick,
  output logic held
);

  localparam int Q_W    = (TICK_M > 1)       ? $clog2(TICK_M)       : 1;
  localparam int HOLD_W = (LONG_TICKS > 1)   ? $clog2(LONG_TICKS)   : 1;
  localparam int REP_W  = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  localparam logic [Q_W-1:0]    Q_LAST    = Q_W'(TICK_M - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic              r_db_d;
  logic [Q_W-1:0]    r_q;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [REP_W-1:0]  r_rep_cnt;

  logic w_rise;
  logic w_fall;
  logic w_tick;
  logic w_hold_last;
  logic w_rep_last;

  logic w_press_next;
  logic w_release_next;
  logic w_click_next;
  logic w_long_next;
  logic w_repeat_next;
  logic w_held_next;

  assign w_rise      = db & ~r_db_d;
  assign w_fall      = ~db & r_db_d;
  assign w_tick      = (r_q == Q_LAST);
  assign w_hold_last = (r_hold_cnt == HOLD_LAST);
  assign w_rep_last  = (r_rep_cnt == REP_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A release always beats a coinciding tick.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) w_state_next = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (w_fall)                     w_state_next = ST_IDLE;
        else if (w_tick && w_hold_last) w_state_next = ST_LONG;
      end
      ST_LONG: begin
        if (w_fall) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    w_click_next   = 1'b0;
    w_long_next    = 1'b0;
    w_repeat_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_press_next = w_rise;
      end
      ST_PRESSED: begin
        w_release_next = w_fall;
        w_click_next   = w_fall;
        w_long_next    = ~w_fall & w_tick & w_hold_last;
      end
      ST_LONG: begin
        w_release_next = w_fall;
        w_repeat_next  = ~w_fall & w_tick & w_rep_last;
      end
      default: ;
    endcase
    w_held_next = (w_state_next == ST_PRESSED) || (w_state_next == ST_LONG);
  end

  // db_d resets high so a button held through reset needs a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_d     <= 1'b1;
      r_q        <= '0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
    end else begin
      r_db_d <= db;
      if ((w_state_next != r_state) || w_tick) begin
        r_q <= '0;
      end else begin
        r_q <= r_q + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_rise) r_hold_cnt <= '0;
        end
        ST_PRESSED: begin
          if (!w_fall && w_tick) begin
            if (w_hold_last) r_rep_cnt  <= '0;
            else             r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_LONG: begin
          if (!w_fall && w_tick) begin
            if (w_rep_last) r_rep_cnt <= '0;
            else            r_rep_cnt <= r_rep_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      click_tick   <= 1'b0;
      long_tick    <= 1'b0;
      repeat_tick  <= 1'b0;
      held         <= 1'b0;
    end else begin
      press_tick   <= w_press_next;
      release_tick <= w_release_next;
      click_tick   <= w_click_next;
      long_tick    <= w_long_next;
      repeat_tick  <= w_repeat_next;
      held         <= w_held_next;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench: stimulus pushes expected events with their cycle stamp,
// a negedge monitor pops and compares whenever any event pulse appears.
module tb_button_event_decoder;

  localparam int TICK_M       = 4;
  localparam int LONG_TICKS   = 3;
  localparam int REPEAT_TICKS = 2;

  localparam logic [4:0] EV_P  = 5'b10000;
  localparam logic [4:0] EV_RC = 5'b01100;
  localparam logic [4:0] EV_R  = 5'b01000;
  localparam logic [4:0] EV_L  = 5'b00010;
  localparam logic [4:0] EV_RP = 5'b00001;

  logic clk = 1'b0;
  logic reset;
  logic db;
  logic press_tick, release_tick, click_tick, long_tick, repeat_tick, held;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
    logic       held;
  } exp_t;

  exp_t sb[$];

  button_event_decoder #(
    .TICK_M      (TICK_M),
    .LONG_TICKS  (LONG_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .db          (db),
    .press_tick  (press_tick),
    .release_tick(release_tick),
    .click_tick  (click_tick),
    .long_tick   (long_tick),
    .repeat_tick (repeat_tick),
    .held        (held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] events();
    return {press_tick, release_tick, click_tick, long_tick, repeat_tick};
  endfunction

  task automatic push(input int c, input logic [4:0] ev, input logic h);
    exp_t e;
    e.cyc = c; e.ev = ev; e.held = h;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b expected %b at cycle %0d", name, got, exp, cyc);
    end else begin
      $display("[TB] ok   %s: %b at cycle %0d", name, got, cyc);
    end
  endtask

  // Monitor: every cycle with any event pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (cyc >= 1 && events() != 5'b0) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_event: got ev=%b held=%b at cycle %0d, expected none",
                 events(), held, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.ev != events() || e.held !== held) begin
          fails++;
          $display("[TB] FAIL event: got ev=%b held=%b cycle %0d, expected ev=%b held=%b cycle %0d",
                   events(), held, cyc, e.ev, e.held, e.cyc);
        end else begin
          $display("[TB] ok   event ev=%b held=%b at cycle %0d", e.ev, e.held, cyc);
        end
      end
    end
  end

  initial begin
    int c;
    logic db_prev;
    reset = 1'b1;
    db    = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    check("reset_state", {events(), held}, 6'b0);

    // 1: held through reset -> no press until re-pressed
    step(5);
    check("no_press_after_reset", {events(), held}, 6'b0);
    db = 1'b0;
    step(2);
    db = 1'b1;
    c = cyc;
    push(c + 1, EV_P, 1'b1);

    // 2: short press released after 5 cycles
    step(5);
    db = 1'b0;
    push(c + 6, EV_RC, 1'b0);
    step(4);

    // 3: long hold with repeats, then release without click
    db = 1'b1;
    c = cyc;
    push(c + 1,  EV_P,  1'b1);
    push(c + 13, EV_L,  1'b1);
    push(c + 21, EV_RP, 1'b1);
    push(c + 29, EV_RP, 1'b1);
    push(c + 37, EV_RP, 1'b1);
    step(40);
    db = 1'b0;
    push(c + 41, EV_R, 1'b0);
    step(4);

    // 4: fall coincides with the long threshold tick -> click wins
    db = 1'b1;
    c = cyc;
    push(c + 1, EV_P, 1'b1);
    step(12);
    db = 1'b0;
    push(c + 13, EV_RC, 1'b0);
    step(4);

    // 5: reset 3 cycles after long_tick while still held
    db = 1'b1;
    c = cyc;
    push(c + 1,  EV_P, 1'b1);
    push(c + 13, EV_L, 1'b1);
    step(16);
    check("held_before_reset", {events(), held}, 6'b000001);
    reset = 1'b1;
    step(1);
    check("outputs_after_midhold_reset", {events(), held}, 6'b0);
    reset = 1'b0;
    step(30);
    check("quiet_after_reset", {events(), held}, 6'b0);
    db = 1'b0;
    step(3);

    // 6: back-to-back press/release, held follows db one cycle later
    for (int i = 0; i < 10; i++) begin
      db = 1'b1;
      c = cyc;
      push(c + 1, EV_P, 1'b1);
      push(c + 3, EV_RC, 1'b0);
      for (int k = 0; k < 4; k++) begin
        db_prev = db;
        step(1);
        check($sformatf("held_mirror_%0d_%0d", i, k), {5'b0, held}, {5'b0, db_prev});
        if (k == 1) db = 1'b0;
      end
    end

    step(5);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      fails++;
      $display("[TB] FAIL missing_event: got none, expected ev=%b at cycle %0d", e.ev, e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
